// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TGT,
    ST_LEN_H,
    ST_LEN_L,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Bit positions inside the TGT byte
  localparam int SEL_BIT  = 0;
  localparam int LAST_BIT = 7;

  // Memory-select encodings (bit ADDR_W of upg_adr_o)
  localparam logic MEM_INST = 1'b0;
  localparam logic MEM_DATA = 1'b1;

endpackage

// File: rtl/word_assembler.sv
// Collects payload bytes into little-endian 32-bit words and keeps the
// running XOR checksum of every payload byte seen since the last clear.
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  data,
  output logic [31:0] word_next,
  output logic        word_ready,
  output logic [7:0]  chk
);

  logic [1:0]  idx;
  logic [23:0] low;

  // The 4th byte is never stored: it goes straight into the word
  // presented alongside word_ready.
  assign word_ready = byte_en && (idx == 2'd3);
  assign word_next  = {data, low};

  // Byte-index counter, lower-byte fill register and running checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 2'd0;
      low <= 24'd0;
      chk <= 8'd0;
    end else if (clear) begin
      idx <= 2'd0;
      low <= 24'd0;
      chk <= 8'd0;
    end else if (byte_en) begin
      idx <= idx + 2'd1;
      chk <= chk ^ data;
      case (idx)
        2'd0:    low[7:0]   <= data;
        2'd1:    low[15:8]  <= data;
        2'd2:    low[23:16] <= data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Frame parser for the memory upgrade port: turns the UART byte stream
// into word writes for the instruction ROM / data RAM and signals done.
module uart_prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W      = 14,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] SOF         = SOF_DEFAULT
) (
  input  logic              upg_clk_i,
  input  logic              upg_rstn_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              upg_wen_o,
  output logic [ADDR_W:0]   upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              frame_ok_o,
  output logic              err_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t            state;
  logic              sel;
  logic              last;
  logic [7:0]        len_h;
  logic [15:0]       words_left;
  logic [ADDR_W-1:0] word_idx;
  logic [TW-1:0]     tmo_cnt;

  logic              active;
  logic              tmo_hit;
  logic [15:0]       len_val;
  logic              byte_en;
  logic              asm_clear;
  logic [31:0]       word_next;
  logic              word_ready;
  logic [7:0]        chk;

  assign active    = (state != ST_IDLE) && (state != ST_DONE);
  assign tmo_hit   = active && !rx_valid_i && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign len_val   = {len_h, rx_data_i};
  assign byte_en   = rx_valid_i && (state == ST_PAYLOAD);
  // Leaving LEN_L covers both "entry to PAYLOAD" and the N = 0 case;
  // a timeout drops whatever partial word was collected.
  assign asm_clear = (state == ST_IDLE) || ((state == ST_LEN_L) && rx_valid_i) || tmo_hit;

  word_assembler u_asm (
    .clk        (upg_clk_i),
    .rst_n      (upg_rstn_i),
    .clear      (asm_clear),
    .byte_en    (byte_en),
    .data       (rx_data_i),
    .word_next  (word_next),
    .word_ready (word_ready),
    .chk        (chk)
  );

  // Frame FSM with timeout, word counters and registered upgrade outputs
  always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
    if (!upg_rstn_i) begin
      state      <= ST_IDLE;
      sel        <= MEM_INST;
      last       <= 1'b0;
      len_h      <= 8'd0;
      words_left <= 16'd0;
      word_idx   <= '0;
      tmo_cnt    <= '0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= 32'd0;
      upg_done_o <= 1'b0;
      frame_ok_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      upg_wen_o  <= 1'b0;
      frame_ok_o <= 1'b0;

      if (rx_valid_i || !active || tmo_hit) tmo_cnt <= '0;
      else                                  tmo_cnt <= tmo_cnt + 1'b1;

      if (tmo_hit) begin
        state <= ST_IDLE;
        err_o <= 1'b1;
      end else if (rx_valid_i) begin
        case (state)
          ST_IDLE: begin
            if (rx_data_i == SOF) state <= ST_TGT;
          end
          ST_TGT: begin
            sel   <= rx_data_i[SEL_BIT];
            last  <= rx_data_i[LAST_BIT];
            state <= ST_LEN_H;
          end
          ST_LEN_H: begin
            len_h <= rx_data_i;
            state <= ST_LEN_L;
          end
          ST_LEN_L: begin
            word_idx   <= '0;
            words_left <= len_val;
            if (len_val == 16'd0) begin
              state <= ST_CHECK;
            end else if ({16'd0, len_val} > (32'd1 << ADDR_W)) begin
              state <= ST_IDLE;
              err_o <= 1'b1;
            end else begin
              state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            if (word_ready) begin
              upg_wen_o  <= 1'b1;
              upg_adr_o  <= {sel, word_idx};
              upg_dat_o  <= word_next;
              word_idx   <= word_idx + 1'b1;
              words_left <= words_left - 16'd1;
              if (words_left == 16'd1) state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (rx_data_i == chk) begin
              frame_ok_o <= 1'b1;
              if (last) begin
                upg_done_o <= 1'b1;
                state      <= ST_DONE;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              err_o <= 1'b1;
              state <= ST_IDLE;
            end
          end
          ST_DONE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: directed frames push expected
// writes / frame_ok events, a monitor pops and compares them.
module tb_uart_prog_loader;

  localparam int ADDR_W  = 14;
  localparam int TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        wen;
  logic [ADDR_W:0] adr;
  logic [31:0] dat;
  logic        done;
  logic        frame_ok;
  logic        err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [ADDR_W:0] adr;
    logic [31:0]     dat;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_ok[$];

  logic rx_at_edge = 1'b0;
  logic wen_prev   = 1'b0;

  uart_prog_loader #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT),
    .SOF         (8'hA5)
  ) dut (
    .upg_clk_i  (clk),
    .upg_rstn_i (rstn),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .upg_wen_o  (wen),
    .upg_adr_o  (adr),
    .upg_dat_o  (dat),
    .upg_done_o (done),
    .frame_ok_o (frame_ok),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Capture what the DUT saw at each active edge
  always @(posedge clk) begin
    rx_at_edge <= rx_valid;
    wen_prev   <= wen;
  end

  // Monitor: compare every write and frame_ok pulse against the queues
  always @(negedge clk) begin
    if (rstn) begin
      if (wen) begin
        check("wr_latency", {31'd0, rx_at_edge}, 32'd1);
        check("wr_back2back", {31'd0, wen_prev}, 32'd0);
        if (exp_wr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got adr=%0h dat=%0h expected none", adr, dat);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_adr", 32'(adr), 32'(e.adr));
          check("wr_dat", dat, e.dat);
        end
      end
      if (frame_ok) begin
        if (exp_ok.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame_ok: got 1 expected 0");
        end else begin
          void'(exp_ok.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[7:0]);
    send(w[15:8]);
    send(w[23:16]);
    send(w[31:24]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_wr(input logic [ADDR_W:0] a, input logic [31:0] d);
    wr_t e;
    e.adr = a;
    e.dat = d;
    exp_wr.push_back(e);
  endtask

  task automatic drain(input string tag);
    idle(4);
    check({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    check({tag, "_ok_left"}, 32'(exp_ok.size()), 32'd0);
    exp_wr.delete();
    exp_ok.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wen"},  {31'd0, wen}, 32'd0);
    check({tag, "_adr"},  32'(adr), 32'd0);
    check({tag, "_dat"},  dat, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_ok"},   {31'd0, frame_ok}, 32'd0);
    check({tag, "_err"},  {31'd0, err}, 32'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check_zero("rst");
    @(negedge clk);
    rstn = 1'b1;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_zero("init");
    rstn = 1'b1;
    idle(2);

    // Garbage before SOF, then two-word data-RAM frame, not last
    send(8'h00); send(8'hFF); send(8'h13);
    push_wr(15'h4000, 32'h0000_0001);
    push_wr(15'h4001, 32'h0000_0002);
    exp_ok.push_back(1);
    send(8'hA5); send(8'h01); send(8'h00); send(8'h02);
    send_word(32'h1); send_word(32'h2);
    send(8'h03);
    drain("two_words");
    check("two_words_done", {31'd0, done}, 32'd0);
    check("two_words_err", {31'd0, err}, 32'd0);

    // Oversized length
    send(8'hA5); send(8'h00); send(8'h40); send(8'h01);
    drain("len_big");
    check("len_big_err", {31'd0, err}, 32'd1);
    do_reset();

    // Single-word last frame to instruction ROM
    push_wr(15'h0000, 32'h1234_5678);
    exp_ok.push_back(1);
    send(8'hA5); send(8'h80); send(8'h00); send(8'h01);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    send(8'h08);
    drain("last");
    check("last_done", {31'd0, done}, 32'd1);
    check("last_err", {31'd0, err}, 32'd0);
    // Bytes after done are ignored
    send(8'hA5); send(8'h00); send(8'h00); send(8'h01);
    send_word(32'h0403_0201); send(8'h04);
    drain("after_done");
    check("after_done_done", {31'd0, done}, 32'd1);
    do_reset();

    // Bad checksum, then a good last frame
    push_wr(15'h0000, 32'h1234_5678);
    send(8'hA5); send(8'h80); send(8'h00); send(8'h01);
    send_word(32'h1234_5678); send(8'h00);
    drain("bad_chk");
    check("bad_chk_err", {31'd0, err}, 32'd1);
    check("bad_chk_done", {31'd0, done}, 32'd0);
    push_wr(15'h0000, 32'h1234_5678);
    exp_ok.push_back(1);
    send(8'hA5); send(8'h80); send(8'h00); send(8'h01);
    send_word(32'h1234_5678); send(8'h08);
    drain("recover");
    check("recover_done", {31'd0, done}, 32'd1);
    check("recover_err", {31'd0, err}, 32'd1);
    do_reset();

    // Timeout mid-word, then a fresh frame must assemble cleanly
    push_wr(15'h0000, 32'h0403_0201);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h04);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05); send(8'h06);
    idle(TIMEOUT + 10);
    drain("timeout");
    check("timeout_err", {31'd0, err}, 32'd1);
    push_wr(15'h0000, 32'hDDCC_BBAA);
    exp_ok.push_back(1);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h01);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    send(8'h00);
    drain("post_timeout");
    check("post_timeout_done", {31'd0, done}, 32'd0);

    // Reset with half a word collected
    send(8'hA5); send(8'h01); send(8'h00); send(8'h01);
    send(8'h11); send(8'h22);
    do_reset();
    push_wr(15'h4000, 32'h1122_3344);
    exp_ok.push_back(1);
    send(8'hA5); send(8'h81); send(8'h00); send(8'h01);
    send(8'h44); send(8'h33); send(8'h22); send(8'h11);
    send(8'h44);
    drain("post_reset");
    check("post_reset_done", {31'd0, done}, 32'd1);
    check("post_reset_err", {31'd0, err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Writer side of the memory upgrade (upg_*) interface. Consumes the byte stream from the UART receiver, parses programming frames, and assembles little-endian 32-bit words.
- Drives word writes with address, data and write-enable into the instruction-ROM and data-RAM upgrade ports.
- Raises upg_done_o after the final frame so both memories return to normal CPU mode.

Parameters:
- ADDR_W, 14, word-address width of each memory.
- TIMEOUT_CYC, 1000000, idle clock cycles allowed between bytes inside a frame before the frame is abandoned.
- SOF, 8'hA5, start-of-frame byte.

Ports:
- upg_clk_i  in  1  single clock; all logic is on the rising edge.
- upg_rstn_i  in  1  reset, asynchronous and active-low.
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  one-cycle strobe; rx_data_i is valid in that cycle.
- upg_wen_o  out  1  one-cycle write strobe.
- upg_adr_o  out  ADDR_W+1  bit ADDR_W selects the memory (0 = instruction ROM, 1 = data RAM); the low ADDR_W bits are the word address.
- upg_dat_o  out  32  write data.
- upg_done_o  out  1  sticky; programming is complete.
- frame_ok_o  out  1  one-cycle pulse after a frame whose checksum matches.
- err_o  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE. Reset mid-frame discards everything, including a partially assembled word.
- Frame format: SOF, TGT, LEN_H, LEN_L, then 4*N payload bytes, then CHK.
  - TGT bit0 is the memory select; TGT bit7 marks the last frame; the other TGT bits are ignored.
  - N = {LEN_H, LEN_L} is the word count.
  - CHK is the XOR of all payload bytes.
- FSM states: IDLE, TGT, LEN_H, LEN_L, PAYLOAD, CHECK, DONE. Transitions happen only on rx_valid_i, except timeout.
  - IDLE -> TGT when the byte equals SOF; any other byte is ignored and no error is raised.
  - TGT -> LEN_H -> LEN_L, latching each byte.
  - LEN_L, N = 0 -> CHECK.
  - LEN_L, N > 2^ADDR_W -> IDLE and set err_o.
  - LEN_L, otherwise -> PAYLOAD.
  - PAYLOAD: byte index 0..3 within a word fills bits [7:0], [15:8], [23:16], [31:24].
    - On the 4th byte, the next cycle has upg_wen_o=1, upg_dat_o = assembled word, and upg_adr_o = {sel, word_idx}. Latency is 1 cycle from the 4th rx_valid_i.
    - word_idx starts at 0 for every frame and increments after each write.
    - After word N-1 is written -> CHECK.
  - CHECK, next byte:
    - Match: pulse frame_ok_o. If the last flag is set -> DONE, otherwise -> IDLE.
    - Mismatch: set err_o and go to IDLE. Writes already issued are not undone.
  - DONE: upg_done_o=1, held until reset; all further bytes are ignored.
- upg_adr_o and upg_dat_o hold their last values when upg_wen_o=0. upg_wen_o is never high for two consecutive cycles; at most 1 byte/cycle arrives, so at least 4 cycles separate writes.
- Timeout: a counter is cleared on every rx_valid_i and counts in every non-IDLE, non-DONE state. Reaching TIMEOUT_CYC -> IDLE, set err_o, discard the partial word.
- Checksum accumulator clears on entry to PAYLOAD, or when N = 0 (CHK then equals 0).
- rx_valid_i in the same cycle as a write strobe is accepted normally; the next byte is assembled without loss.
- err_o clears only on reset. A later good frame still writes and can still reach DONE.

Decomposition:
- Shared package (prog_loader_pkg):
  - state enum.
  - SOF default.
  - TGT bit positions: SEL_BIT=0, LAST_BIT=7.
  - memory-select encodings: MEM_INST=0, MEM_DATA=1.
- Sub-module word_assembler: byte-index counter, 32-bit shift/fill register, running XOR, word_ready pulse.
- The top level holds the FSM, length/word counters, timeout counter and output registers.

Test Plan:
- Bytes A5 80 00 01 78 56 34 12 08 -> one write with upg_adr_o=15'h0000 and upg_dat_o=32'h12345678, 1 cycle after the byte 12. Then frame_ok_o pulse, upg_done_o=1, err_o=0.
- Bytes A5 01 00 02, then words 1,2 (each sent as 4 little-endian bytes), then correct CHK -> two writes at upg_adr_o=15'h4000 and 15'h4001. frame_ok_o pulses; upg_done_o stays 0.
- Same as the first frame but CHK=00 -> the write still occurs, err_o=1, frame_ok_o=0, upg_done_o=0. A following correct last frame -> upg_done_o=1 with err_o still 1.
- Bytes A5 00 00 04, then 6 payload bytes, then silence for TIMEOUT_CYC cycles (bench sets TIMEOUT_CYC=50) -> exactly 1 write, err_o=1, FSM in IDLE. A new frame is accepted.
- Garbage 00 FF 13 before SOF -> no writes, no error. LEN = 16'h4001 -> err_o=1, no writes.
- Deassert upg_rstn_i during PAYLOAD with 2 of 4 bytes received -> all outputs 0 immediately. After release, a complete frame writes at word address 0.
